// File: rtl/control_salto_predictivo.sv
// control_salto_predictivo: EX-stage RV32I branch resolution with a 2-bit saturating BHT for IF prediction.
// Define CONTROL_SALTO_STATS_EN to add resolved-branch and mispredict counters.
module control_salto_predictivo #(
    parameter int W         = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] pred_pc_i,
    output logic         pred_taken_o,
    input  logic         ex_valid_i,
    input  logic         ex_kill_i,
    input  logic [W-1:0] ex_instr_i,
    input  logic [W-1:0] ex_pc_i,
    input  logic [W-1:0] ex_rs1_i,
    input  logic [W-1:0] ex_rs2_i,
    input  logic         ex_pred_taken_i,
    output logic         salto_o,
`ifdef CONTROL_SALTO_STATS_EN
    output logic         flush_o,
    output logic [31:0]  branch_count_o,
    output logic [31:0]  mispredict_count_o
`else
    output logic         flush_o
`endif
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [2:0]       funct3;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             eq;
    logic             lt;
    logic             ltu;
    logic             taken;
    logic             is_branch;
    logic             mispredict;
    logic [1:0]       cnt;
    logic             unused;

    assign funct3       = ex_instr_i[14:12];
    assign pred_idx     = pred_pc_i[IDX_W+1:2];
    assign ex_idx       = ex_pc_i[IDX_W+1:2];
    assign pred_taken_o = bht[pred_idx][1];
    assign unused       = ^{pred_pc_i[W-1:IDX_W+2], pred_pc_i[1:0], ex_pc_i[W-1:IDX_W+2],
                            ex_pc_i[1:0], ex_instr_i[W-1:15], ex_instr_i[11:7]};

    always_comb begin
        eq         = ex_rs1_i == ex_rs2_i;
        lt         = $signed(ex_rs1_i) < $signed(ex_rs2_i);
        ltu        = ex_rs1_i < ex_rs2_i;
        // funct3[0] inverts the base comparison: bne/bge/bgeu
        taken      = (funct3[2] ? (funct3[1] ? ltu : lt) : eq) ^ funct3[0];
        is_branch  = ex_valid_i & ~ex_kill_i & (ex_instr_i[6:0] == 7'b1100011)
                   & (funct3[2] | ~funct3[1]);
        mispredict = is_branch & (taken != ex_pred_taken_i);
        cnt        = bht[ex_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
            salto_o <= 1'b0;
            flush_o <= 1'b0;
        end else begin
            salto_o <= is_branch & taken;
            flush_o <= mispredict;
            if (is_branch)
                bht[ex_idx] <= taken ? (cnt == 2'b11 ? cnt : cnt + 2'd1)
                                     : (cnt == 2'b00 ? cnt : cnt - 2'd1);
        end
    end

`ifdef CONTROL_SALTO_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_o     <= '0;
            mispredict_count_o <= '0;
        end else begin
            branch_count_o     <= branch_count_o + {31'd0, is_branch};
            mispredict_count_o <= mispredict_count_o + {31'd0, mispredict};
        end
    end
`endif
endmodule

// File: tb/tb_control_salto_predictivo.sv
// tb_control_salto_predictivo: directed checks of branch resolution, BHT training and flush generation.
module tb_control_salto_predictivo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pred_pc_i = '0;
    logic        pred_taken_o;
    logic        ex_valid_i = 1'b0;
    logic        ex_kill_i = 1'b0;
    logic [31:0] ex_instr_i = '0;
    logic [31:0] ex_pc_i = '0;
    logic [31:0] ex_rs1_i = '0;
    logic [31:0] ex_rs2_i = '0;
    logic        ex_pred_taken_i = 1'b0;
    logic        salto_o;
    logic        flush_o;
`ifdef CONTROL_SALTO_STATS_EN
    logic [31:0] branch_count_o;
    logic [31:0] mispredict_count_o;
`endif
    int checks = 0;
    int fails = 0;

    control_salto_predictivo dut (
        .clk(clk), .rst_n(rst_n), .pred_pc_i(pred_pc_i), .pred_taken_o(pred_taken_o),
        .ex_valid_i(ex_valid_i), .ex_kill_i(ex_kill_i), .ex_instr_i(ex_instr_i),
        .ex_pc_i(ex_pc_i), .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i),
        .ex_pred_taken_i(ex_pred_taken_i), .salto_o(salto_o),
`ifdef CONTROL_SALTO_STATS_EN
        .branch_count_o(branch_count_o), .mispredict_count_o(mispredict_count_o),
`endif
        .flush_o(flush_o)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        ex_valid_i = 1'b0;
        ex_kill_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Presents one EX instruction for a single edge, then idles EX; outputs are checked afterwards.
    task automatic issue(input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic pred,
                         input logic kill);
        ex_valid_i = 1'b1;
        ex_kill_i = kill;
        ex_instr_i = {17'd0, f3, 5'd0, op};
        ex_pc_i = pc;
        ex_rs1_i = a;
        ex_rs2_i = b;
        ex_pred_taken_i = pred;
        @(posedge clk);
        #1;
        ex_valid_i = 1'b0;
        ex_kill_i = 1'b0;
    endtask

    task automatic check_out(input string name, input logic s, input logic f);
        checks += 2;
        if (salto_o !== s) begin
            fails++;
            $display("FAIL %s salto_o got %b expected %b", name, salto_o, s);
        end
        if (flush_o !== f) begin
            fails++;
            $display("FAIL %s flush_o got %b expected %b", name, flush_o, f);
        end
    endtask

    task automatic check_pred(input string name, input logic [31:0] pc, input logic p);
        pred_pc_i = pc;
        #1;
        checks++;
        if (pred_taken_o !== p) begin
            fails++;
            $display("FAIL %s pred_taken_o@%h got %b expected %b", name, pc, pred_taken_o, p);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        check_out("reset_outputs", 1'b0, 1'b0);
        do_reset();
        check_pred("reset_pred_100", 32'h100, 1'b0);
        // A taken branch moves 01->10 (pred 1); an entry reset to 00 would stay not-taken.
        for (int i = 0; i < 64; i++) begin
            issue(32'(i * 4), 7'b1100011, 3'b000, 32'd1, 32'd1, 1'b0, 1'b0);
            check_pred("reset_probe", 32'(i * 4), 1'b1);
        end
        do_reset();
    endtask

    task automatic test_beq();
        issue(32'h100, 7'b1100011, 3'b000, 32'd5, 32'd5, 1'b0, 1'b0);
        check_out("beq_taken", 1'b1, 1'b1);
        check_pred("beq_bht", 32'h100, 1'b1);
        check_pred("beq_other_idx", 32'h104, 1'b0);
        @(posedge clk);
        #1;
        check_out("beq_flush_one_cycle", 1'b0, 1'b0);
    endtask

    task automatic test_compare();
        issue(32'h10, 7'b1100011, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        check_out("blt_neg", 1'b1, 1'b1);
        issue(32'h10, 7'b1100011, 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        check_out("bltu_big", 1'b0, 1'b0);
        issue(32'h10, 7'b1100011, 3'b101, 32'd7, 32'd7, 1'b1, 1'b0);
        check_out("bge_eq", 1'b1, 1'b0);
        issue(32'h10, 7'b1100011, 3'b111, 32'd7, 32'd7, 1'b1, 1'b0);
        check_out("bgeu_eq", 1'b1, 1'b0);
        issue(32'h10, 7'b1100011, 3'b001, 32'd7, 32'd7, 1'b1, 1'b0);
        check_out("bne_eq", 1'b0, 1'b1);
        issue(32'h10, 7'b1100011, 3'b001, 32'd7, 32'h8000_0007, 1'b0, 1'b0);
        check_out("bne_msb", 1'b1, 1'b1);
        issue(32'h10, 7'b1100011, 3'b000, 32'd7, 32'h8000_0007, 1'b0, 1'b0);
        check_out("beq_msb", 1'b0, 1'b0);
        issue(32'h10, 7'b1100011, 3'b101, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        check_out("bge_neg", 1'b0, 1'b0);
        issue(32'h10, 7'b1100011, 3'b111, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        check_out("bgeu_big", 1'b1, 1'b1);
        issue(32'h10, 7'b1100011, 3'b100, 32'd1, 32'd1, 1'b0, 1'b0);
        check_out("blt_eq", 1'b0, 1'b0);
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 5; i++) issue(32'h204, 7'b1100011, 3'b000, 32'd3, 32'd3, 1'b1, 1'b0);
        check_out("sat_taken", 1'b1, 1'b0);
        check_pred("sat_11", 32'h204, 1'b1);
        issue(32'h204, 7'b1100011, 3'b001, 32'd3, 32'd3, 1'b1, 1'b0);
        check_out("sat_nt_flush", 1'b0, 1'b1);
        check_pred("sat_10", 32'h204, 1'b1);
        @(posedge clk);
        #1;
        check_out("sat_flush_once", 1'b0, 1'b0);
        issue(32'h204, 7'b1100011, 3'b001, 32'd3, 32'd3, 1'b1, 1'b0);
        check_pred("sat_01", 32'h204, 1'b0);
        for (int i = 0; i < 3; i++) issue(32'h204, 7'b1100011, 3'b001, 32'd3, 32'd3, 1'b0, 1'b0);
        issue(32'h204, 7'b1100011, 3'b000, 32'd3, 32'd3, 1'b0, 1'b0);
        check_pred("sat_00_then_01", 32'h204, 1'b0);
        // pc[1:0] must not affect the index
        issue(32'h207, 7'b1100011, 3'b000, 32'd3, 32'd3, 1'b0, 1'b0);
        check_pred("idx_ignore_low", 32'h204, 1'b1);
    endtask

    task automatic test_not_branch();
        do_reset();
        issue(32'h300, 7'b1100011, 3'b000, 32'd1, 32'd1, 1'b0, 1'b1);
        check_out("kill", 1'b0, 1'b0);
        check_pred("kill_bht", 32'h300, 1'b0);
        issue(32'h300, 7'b1100011, 3'b010, 32'd1, 32'd1, 1'b0, 1'b0);
        check_out("f3_010", 1'b0, 1'b0);
        issue(32'h300, 7'b1100011, 3'b011, 32'd1, 32'd2, 1'b1, 1'b0);
        check_out("f3_011", 1'b0, 1'b0);
        issue(32'h300, 7'b1100111, 3'b000, 32'd1, 32'd1, 1'b1, 1'b0);
        check_out("bad_opcode", 1'b0, 1'b0);
        ex_instr_i = {17'd0, 3'b000, 5'd0, 7'b1100011};
        ex_rs1_i = 32'd1;
        ex_rs2_i = 32'd1;
        @(posedge clk);
        #1;
        check_out("not_valid", 1'b0, 1'b0);
        check_pred("not_branch_bht", 32'h300, 1'b0);
        issue(32'h300, 7'b1100011, 3'b000, 32'd1, 32'd1, 1'b0, 1'b0);
        check_out("pre_reset", 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 1'b0);
        check_pred("async_reset_bht", 32'h300, 1'b0);
        do_reset();
    endtask

`ifdef CONTROL_SALTO_STATS_EN
    task automatic test_stats();
        do_reset();
        checks += 2;
        if (branch_count_o !== 32'd0 || mispredict_count_o !== 32'd0) begin
            fails += 2;
            $display("FAIL stats_reset got %0d/%0d expected 0/0", branch_count_o, mispredict_count_o);
        end
        issue(32'h40, 7'b1100011, 3'b000, 32'd1, 32'd1, 1'b0, 1'b0);
        issue(32'h40, 7'b1100011, 3'b000, 32'd1, 32'd2, 1'b0, 1'b0);
        issue(32'h40, 7'b1100011, 3'b000, 32'd1, 32'd1, 1'b0, 1'b1);
        issue(32'h40, 7'b1100011, 3'b001, 32'd1, 32'd2, 1'b0, 1'b0);
        checks++;
        if (branch_count_o !== 32'd3) begin
            fails++;
            $display("FAIL stats_branch got %0d expected 3", branch_count_o);
        end
        checks++;
        if (mispredict_count_o !== 32'd2) begin
            fails++;
            $display("FAIL stats_mispredict got %0d expected 2", mispredict_count_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_beq();
        test_compare();
        test_saturate();
        test_not_branch();
`ifdef CONTROL_SALTO_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
